mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the 5-stage RISC-V pipeline. Sits between the ex_m register (ALU result, rd address, store data, load/store controls) and m_wb.
- Runs the valid/ready handshake with data memory for LB/LH/LW/LBU/LHU/SB/SH/SW, including byte-lane steering and load sign/zero extension.
- Passes non-memory results straight through, stalls upstream while a memory access is outstanding, and drives registered writeback outputs.

Parameters:
- ADDR_W, 32, width of the data address bus.
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  EX result present
- in_ready  out  1  stage can accept; low means stall upstream
- in_rd_addr  in  5  destination register
- in_result  in  XLEN  ALU output: effective address for load/store, rd value otherwise
- in_store_data  in  XLEN  rs2 value for stores
- in_load  in  1  instruction is a load
- in_store  in  1  instruction is a store
- in_funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- in_writeback_en  in  1  instruction writes rd
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_req_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
- dmem_req_we  out  1  1 = store
- dmem_req_wdata  out  XLEN  lane-replicated store data
- dmem_req_be  out  4  byte enables
- dmem_resp_valid  in  1  load data valid
- dmem_resp_rdata  in  XLEN  load word
- out_valid  out  1  result to m_wb valid (one cycle per instruction)
- out_rd_addr  out  5  destination register
- out_rd  out  XLEN  writeback value
- out_writeback_en  out  1  write register file
- misaligned  out  1  one-cycle fault pulse, coincident with out_valid

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0 except in_ready=1. Any outstanding request is dropped and a later dmem_resp_valid is ignored.
- FSM states:
  - IDLE: in_ready=1. Accept on in_valid&in_ready.
  - REQ: dmem_req_valid=1. Address, we, wdata and be are registered and held stable until dmem_req_ready.
  - WAIT: load outstanding, waiting for dmem_resp_valid.
- in_ready=1 only in IDLE.
- Non-memory op (in_load=in_store=0):
  - Stay in IDLE; out_rd=in_result at the next edge.
  - Latency 1, throughput 1/cycle for back-to-back ops.
- Load/store with legal, aligned access: go to REQ.
  - Store: on the req handshake, go to IDLE. out_valid next cycle with out_writeback_en=0.
  - Load: on the req handshake, go to WAIT. dmem_resp_valid in WAIT latches the extracted data, out_valid fires next cycle, then go to IDLE.
- dmem_req_ready held high → best-case load latency is accept(t), req(t+1), resp(t+2), out_valid(t+3).
- Alignment faults: H/HU with addr[0]=1, W with addr[1:0]≠0, or funct3 ∈ {011,110,111}.
  - No request is issued.
  - Next cycle: out_valid=1, misaligned=1, out_writeback_en=0.
- in_load and in_store both high: treated as a load.
- Store lanes:
  - SB: be=1<<addr[1:0], wdata={4{data[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata={2{data[15:0]}}.
  - SW: be=1111, wdata=data.
  - Loads drive be=1111 and we=0.
- Load extract:
  - B/BU: byte lane addr[1:0].
  - H/HU: half lane addr[1].
  - W: full word.
  - B/H sign-extend; BU/HU zero-extend.
- out_writeback_en = captured in_writeback_en & (rd≠0) & ~store & ~fault.
- dmem_resp_valid outside WAIT: ignored.
- out_valid and misaligned are single-cycle pulses, then clear.
- out_rd_addr and out_rd hold their last value while out_valid=0.

Test Plan:
- ALU passthrough: in_valid=1, result=0x12345678, rd=5, wb=1, for 3 consecutive cycles → out_valid each following cycle, out_rd=0x12345678, out_writeback_en=1, in_ready stays 1.
- LB sign-extend: addr=0x103, funct3=000; memory returns 0x80FF_FF_FF with ready=1 and resp one cycle after handshake → req addr=0x100, be=1111, we=0; out_rd=0xFFFFFF80; out_valid at t+3; in_ready low t+1..t+3.
- SH upper half: addr=0x202, data=0xAAAABEEF; ready held low 3 cycles → req_valid held 3+ cycles with addr 0x200, be=1100, wdata=0xBEEFBEEF, all stable; out_valid the cycle after the handshake with out_writeback_en=0.
- LW misaligned: addr=0x301, funct3=010 → no req_valid; next cycle out_valid=1, misaligned=1, out_writeback_en=0; in_ready back to 1.
- LHU plus rd=0: addr=0x002, resp=0x9876_0000, rd=0 → out_rd=0x00009876, out_writeback_en=0.
- Reset in WAIT: rst=0 while awaiting a response, then a stray resp_valid after release → all outputs 0, in_ready=1, no out_valid generated.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: passes ALU results to m_wb, or runs one data-memory access per
// load/store with byte-lane steering, load extension and alignment checks.
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rd_addr,
    input  logic [XLEN-1:0]   in_result,
    input  logic [XLEN-1:0]   in_store_data,
    input  logic              in_load,
    input  logic              in_store,
    input  logic [2:0]        in_funct3,
    input  logic              in_writeback_en,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic [ADDR_W-1:0] dmem_req_addr,
    output logic              dmem_req_we,
    output logic [XLEN-1:0]   dmem_req_wdata,
    output logic [3:0]        dmem_req_be,
    input  logic              dmem_resp_valid,
    input  logic [XLEN-1:0]   dmem_resp_rdata,
    output logic              out_valid,
    output logic [4:0]        out_rd_addr,
    output logic [XLEN-1:0]   out_rd,
    output logic              out_writeback_en,
    output logic              misaligned,
    output logic [1:0]        dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; a request's payload stays stable from valid until that edge.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [XLEN-1:0]   r_wdata;
    logic [3:0]        r_be;
    logic [2:0]        r_funct3;
    logic [1:0]        r_off;
    logic [4:0]        r_rd_addr;
    logic              r_wb_en;
    logic              r_resp_done;
    logic              r_out_valid;
    logic [4:0]        r_out_rd_addr;
    logic [XLEN-1:0]   r_out_rd;
    logic              r_out_wb;
    logic              r_misaligned;

    logic              w_accept;
    logic              w_is_mem;
    logic              w_is_store;
    logic [1:0]        w_off;
    logic              w_fault;
    logic [3:0]        w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [XLEN-1:0]   w_load_data;

    assign w_accept   = in_valid && (r_state == S_IDLE);
    assign w_is_mem   = in_load || in_store;
    assign w_is_store = in_store && !in_load;
    assign w_off      = in_result[1:0];

    always_comb begin
        w_fault = 1'b0;
        if (w_is_mem) begin
            case (in_funct3)
                3'b000, 3'b100: w_fault = 1'b0;
                3'b001, 3'b101: w_fault = w_off[0];
                3'b010:         w_fault = |w_off;
                default:        w_fault = 1'b1;
            endcase
        end
    end

    // Store data is replicated across lanes so memory only needs the enables.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = '0;
        if (w_is_store) begin
            case (in_funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << w_off;
                    w_wdata = {4{in_store_data[7:0]}};
                end
                2'b01: begin
                    w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{in_store_data[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = in_store_data;
                end
            endcase
        end
    end

    always_comb begin
        case (r_off)
            2'd0:    w_byte = dmem_resp_rdata[7:0];
            2'd1:    w_byte = dmem_resp_rdata[15:8];
            2'd2:    w_byte = dmem_resp_rdata[23:16];
            default: w_byte = dmem_resp_rdata[31:24];
        endcase
        w_half = r_off[1] ? dmem_resp_rdata[31:16] : dmem_resp_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
            3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
            3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
            default: w_load_data = dmem_resp_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_we          <= 1'b0;
            r_wdata       <= '0;
            r_be          <= 4'b0000;
            r_funct3      <= 3'b000;
            r_off         <= 2'b00;
            r_rd_addr     <= 5'd0;
            r_wb_en       <= 1'b0;
            r_resp_done   <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_rd_addr <= 5'd0;
            r_out_rd      <= '0;
            r_out_wb      <= 1'b0;
            r_misaligned  <= 1'b0;
        end else begin
            r_out_valid  <= 1'b0;
            r_misaligned <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rd_addr <= in_rd_addr;
                        r_wb_en   <= in_writeback_en && (in_rd_addr != 5'd0);
                        if (!w_is_mem || w_fault) begin
                            r_out_valid   <= 1'b1;
                            r_misaligned  <= w_fault;
                            r_out_rd_addr <= in_rd_addr;
                            r_out_rd      <= in_result;
                            r_out_wb      <= in_writeback_en && (in_rd_addr != 5'd0) && !w_is_mem;
                        end else begin
                            r_state  <= S_REQ;
                            r_addr   <= {in_result[ADDR_W-1:2], 2'b00};
                            r_we     <= w_is_store;
                            r_wdata  <= w_wdata;
                            r_be     <= w_be;
                            r_funct3 <= in_funct3;
                            r_off    <= w_off;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_req_ready) begin
                        if (r_we) begin
                            r_state       <= S_IDLE;
                            r_out_valid   <= 1'b1;
                            r_out_rd_addr <= r_rd_addr;
                            r_out_wb      <= 1'b0;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // Stay one extra cycle so upstream remains stalled while the result drains.
                    if (r_resp_done) begin
                        r_state     <= S_IDLE;
                        r_resp_done <= 1'b0;
                    end else if (dmem_resp_valid) begin
                        r_resp_done   <= 1'b1;
                        r_out_valid   <= 1'b1;
                        r_out_rd_addr <= r_rd_addr;
                        r_out_rd      <= w_load_data;
                        r_out_wb      <= r_wb_en;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready         = (r_state == S_IDLE);
    assign dmem_req_valid   = (r_state == S_REQ);
    assign dmem_req_addr    = r_addr;
    assign dmem_req_we      = r_we;
    assign dmem_req_wdata   = r_wdata;
    assign dmem_req_be      = r_be;
    assign out_valid        = r_out_valid;
    assign out_rd_addr      = r_out_rd_addr;
    assign out_rd           = r_out_rd;
    assign out_writeback_en = r_out_wb;
    assign misaligned       = r_misaligned;
    assign dbg_state        = r_state;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a result scoreboard checked on every out_valid.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd_addr;
    logic [31:0] in_result;
    logic [31:0] in_store_data;
    logic        in_load;
    logic        in_store;
    logic [2:0]  in_funct3;
    logic        in_writeback_en;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_req_addr;
    logic        dmem_req_we;
    logic [31:0] dmem_req_wdata;
    logic [3:0]  dmem_req_be;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_rdata;
    logic        out_valid;
    logic [4:0]  out_rd_addr;
    logic [31:0] out_rd;
    logic        out_writeback_en;
    logic        misaligned;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    // Entry layout: {rd_care, misaligned, writeback_en, rd_addr[4:0], rd[31:0]}
    logic [39:0] exp_q[$];

    mem_stage #(.ADDR_W(32), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd_addr(in_rd_addr), .in_result(in_result), .in_store_data(in_store_data),
        .in_load(in_load), .in_store(in_store), .in_funct3(in_funct3),
        .in_writeback_en(in_writeback_en),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_addr(dmem_req_addr), .dmem_req_we(dmem_req_we),
        .dmem_req_wdata(dmem_req_wdata), .dmem_req_be(dmem_req_be),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
        .out_valid(out_valid), .out_rd_addr(out_rd_addr), .out_rd(out_rd),
        .out_writeback_en(out_writeback_en), .misaligned(misaligned),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid        = 1'b0;
        in_load         = 1'b0;
        in_store        = 1'b0;
        in_funct3       = 3'b000;
        in_rd_addr      = 5'd0;
        in_result       = 32'h0;
        in_store_data   = 32'h0;
        in_writeback_en = 1'b0;
    endtask

    task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] res, input logic [31:0] sdata,
                            input logic [4:0] rd, input logic wb);
        in_valid        = 1'b1;
        in_load         = ld;
        in_store        = st;
        in_funct3       = f3;
        in_result       = res;
        in_store_data   = sdata;
        in_rd_addr      = rd;
        in_writeback_en = wb;
    endtask

    task automatic push_exp(input logic care, input logic mis, input logic wb,
                            input logic [4:0] rd, input logic [31:0] val);
        exp_q.push_back({care, mis, wb, rd, val});
    endtask

    // scoreboard: every out_valid pulse consumes exactly one expected entry
    always @(negedge clk) begin
        if (rst && out_valid) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_out_valid observed=1 expected=0");
            end
            if (exp_q.size() != 0) begin
                logic [39:0] e;
                e = exp_q.pop_front();
                check("sb_misaligned", 64'(misaligned), 64'(e[38]));
                check("sb_wb_en", 64'(out_writeback_en), 64'(e[37]));
                check("sb_rd_addr", 64'(out_rd_addr), 64'(e[36:32]));
                if (e[39]) check("sb_rd", 64'(out_rd), 64'(e[31:0]));
            end
        end
    end

    initial begin
        logic [31:0] r_res;
        logic [4:0]  r_rd;
        logic        r_wb;

        rst             = 1'b0;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = 32'h0;
        idle_in();
        tick();
        tick();

        // reset state
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_req_valid", 64'(dmem_req_valid), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_rd", 64'(out_rd), 64'd0);
        check("rst_misaligned", 64'(misaligned), 64'd0);
        check("rst_req_be", 64'(dmem_req_be), 64'd0);
        rst = 1'b1;
        tick();

        // ALU passthrough, back to back
        for (int i = 0; i < 3; i++) begin
            drive_op(1'b0, 1'b0, 3'b000, 32'h12345678, 32'h0, 5'd5, 1'b1);
            push_exp(1'b1, 1'b0, 1'b1, 5'd5, 32'h12345678);
            check("alu_in_ready", 64'(in_ready), 64'd1);
            tick();
            if (i > 0) check("alu_out_valid", 64'(out_valid), 64'd1);
        end
        for (int i = 0; i < 4; i++) begin
            r_res = $urandom;
            r_rd  = 5'($urandom_range(0, 31));
            r_wb  = 1'($urandom_range(0, 1));
            drive_op(1'b0, 1'b0, 3'($urandom_range(0, 7)), r_res, 32'h0, r_rd, r_wb);
            push_exp(1'b1, 1'b0, r_wb && (r_rd != 5'd0), r_rd, r_res);
            tick();
            check("alu_rand_out_valid", 64'(out_valid), 64'd1);
        end
        idle_in();
        tick();
        check("alu_pulse_clear", 64'(out_valid), 64'd0);
        tick();

        // LB sign-extend, ready held high, response one cycle after handshake
        dmem_req_ready = 1'b1;
        drive_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd7, 1'b1);
        push_exp(1'b1, 1'b0, 1'b1, 5'd7, 32'hFFFFFF80);
        tick();
        idle_in();
        check("lb_t1_in_ready", 64'(in_ready), 64'd0);
        check("lb_t1_req_valid", 64'(dmem_req_valid), 64'd1);
        check("lb_req_addr", 64'(dmem_req_addr), 64'h100);
        check("lb_req_be", 64'(dmem_req_be), 64'hF);
        check("lb_req_we", 64'(dmem_req_we), 64'd0);
        tick();
        check("lb_t2_in_ready", 64'(in_ready), 64'd0);
        check("lb_t2_req_valid", 64'(dmem_req_valid), 64'd0);
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h80FFFFFF;
        tick();
        dmem_resp_valid = 1'b0;
        check("lb_t3_out_valid", 64'(out_valid), 64'd1);
        check("lb_t3_in_ready", 64'(in_ready), 64'd0);
        tick();
        check("lb_t4_in_ready", 64'(in_ready), 64'd1);
        check("lb_t4_out_valid", 64'(out_valid), 64'd0);

        // SH upper half with ready held low for 3 cycles
        dmem_req_ready = 1'b0;
        drive_op(1'b0, 1'b1, 3'b001, 32'h202, 32'hAAAABEEF, 5'd3, 1'b1);
        push_exp(1'b0, 1'b0, 1'b0, 5'd3, 32'h0);
        tick();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            check("sh_req_valid", 64'(dmem_req_valid), 64'd1);
            check("sh_req_addr", 64'(dmem_req_addr), 64'h200);
            check("sh_req_be", 64'(dmem_req_be), 64'hC);
            check("sh_req_wdata", 64'(dmem_req_wdata), 64'hBEEFBEEF);
            check("sh_req_we", 64'(dmem_req_we), 64'd1);
            check("sh_out_valid", 64'(out_valid), 64'd0);
            if (i == 2) dmem_req_ready = 1'b1;
            tick();
        end
        check("sh_done_out_valid", 64'(out_valid), 64'd1);
        check("sh_done_req_valid", 64'(dmem_req_valid), 64'd0);
        check("sh_done_in_ready", 64'(in_ready), 64'd1);
        tick();

        // SB to lane 1
        drive_op(1'b0, 1'b1, 3'b000, 32'h1001, 32'h123456CD, 5'd2, 1'b1);
        push_exp(1'b0, 1'b0, 1'b0, 5'd2, 32'h0);
        tick();
        idle_in();
        check("sb_req_be", 64'(dmem_req_be), 64'h2);
        check("sb_req_wdata", 64'(dmem_req_wdata), 64'hCDCDCDCD);
        check("sb_req_addr", 64'(dmem_req_addr), 64'h1000);
        tick();
        tick();

        // LW misaligned and an illegal funct3: no request, fault pulse
        drive_op(1'b1, 1'b0, 3'b010, 32'h301, 32'h0, 5'd9, 1'b1);
        push_exp(1'b0, 1'b1, 1'b0, 5'd9, 32'h0);
        tick();
        idle_in();
        check("lw_mis_req_valid", 64'(dmem_req_valid), 64'd0);
        check("lw_mis_out_valid", 64'(out_valid), 64'd1);
        check("lw_mis_flag", 64'(misaligned), 64'd1);
        check("lw_mis_in_ready", 64'(in_ready), 64'd1);
        drive_op(1'b0, 1'b1, 3'b011, 32'h400, 32'h0, 5'd10, 1'b1);
        push_exp(1'b0, 1'b1, 1'b0, 5'd10, 32'h0);
        tick();
        idle_in();
        check("f3_bad_req_valid", 64'(dmem_req_valid), 64'd0);
        tick();
        check("mis_pulse_clear", 64'(misaligned), 64'd0);

        // LHU upper half with rd=0
        drive_op(1'b1, 1'b0, 3'b101, 32'h002, 32'h0, 5'd0, 1'b1);
        push_exp(1'b1, 1'b0, 1'b0, 5'd0, 32'h00009876);
        tick();
        idle_in();
        tick();
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h98760000;
        tick();
        dmem_resp_valid = 1'b0;
        tick();

        // LH sign-extend low half, load+store both high treated as load
        drive_op(1'b1, 1'b1, 3'b001, 32'h010, 32'hFFFFFFFF, 5'd12, 1'b1);
        push_exp(1'b1, 1'b0, 1'b1, 5'd12, 32'hFFFF8001);
        tick();
        idle_in();
        check("lh_req_we", 64'(dmem_req_we), 64'd0);
        tick();
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h12348001;
        tick();
        dmem_resp_valid = 1'b0;
        tick();
        check("lh_out_rd_hold", 64'(out_rd), 64'hFFFF8001);

        // reset while a load is outstanding, then a stray response
        drive_op(1'b1, 1'b0, 3'b010, 32'h040, 32'h0, 5'd4, 1'b1);
        tick();
        idle_in();
        tick();
        rst = 1'b0;
        #1;
        check("rw_in_ready", 64'(in_ready), 64'd1);
        check("rw_req_valid", 64'(dmem_req_valid), 64'd0);
        check("rw_out_valid", 64'(out_valid), 64'd0);
        check("rw_out_rd", 64'(out_rd), 64'd0);
        check("rw_out_rd_addr", 64'(out_rd_addr), 64'd0);
        check("rw_req_addr", 64'(dmem_req_addr), 64'd0);
        tick();
        rst = 1'b1;
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'hDEADBEEF;
        tick();
        dmem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rw_no_out_valid", 64'(out_valid), 64'd0);
            check("rw_ready_after", 64'(in_ready), 64'd1);
            tick();
        end

        check("sb_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
